// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: two requester handshakes,
// the registered register-file write port, the read bypass and the commit counters.
interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          Hold;
  logic          A_Valid;
  logic [AW-1:0] A_Wr;
  logic [DW-1:0] A_D;
  logic          A_Ready;
  logic          B_Valid;
  logic [AW-1:0] B_Wr;
  logic [DW-1:0] B_D;
  logic          B_Ready;
  logic          We;
  logic [AW-1:0] Wr;
  logic [DW-1:0] D;
  logic [AW-1:0] Ra;
  logic [AW-1:0] Rb;
  logic [DW-1:0] Qa_rf;
  logic [DW-1:0] Qb_rf;
  logic [DW-1:0] Qa;
  logic [DW-1:0] Qb;
  logic [CW-1:0] Cnt_a;
  logic [CW-1:0] Cnt_b;

  // Arbiter side
  modport slave (
    input  Hold, A_Valid, A_Wr, A_D, B_Valid, B_Wr, B_D, Ra, Rb, Qa_rf, Qb_rf,
    output A_Ready, B_Ready, We, Wr, D, Qa, Qb, Cnt_a, Cnt_b
  );

  // Requester / pipeline side
  modport master (
    output Hold, A_Valid, A_Wr, A_D, B_Valid, B_Wr, B_D, Ra, Rb, Qa_rf, Qb_rf,
    input  A_Ready, B_Ready, We, Wr, D, Qa, Qb, Cnt_a, Cnt_b
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// the ALU (A) and load (B) write-back paths. The write stage is registered;
// read data is bypassed from the staged write so readers see it one cycle early.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic                Clk,
  input logic                Clrn,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  req_t          last_reg, last_next;
  logic          we_reg, we_next;
  logic [AW-1:0] wr_reg, wr_next;
  logic [DW-1:0] d_reg, d_next;
  logic [CW-1:0] cnt_a_reg, cnt_a_next;
  logic [CW-1:0] cnt_b_reg, cnt_b_next;
  logic          grant_a, grant_b;

  // Grant selection plus next-state for the pointer, write stage and counters
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    last_next  = last_reg;
    we_next    = 1'b0;
    wr_next    = wr_reg;
    d_next     = d_reg;
    cnt_a_next = cnt_a_reg;
    cnt_b_next = cnt_b_reg;

    // Ready is masked during reset so nothing looks accepted while Clrn is low
    if (Clrn && !bus.Hold) begin
      if (bus.A_Valid && bus.B_Valid) begin
        grant_a = (last_reg == REQ_B);
        grant_b = (last_reg == REQ_A);
      end else begin
        grant_a = bus.A_Valid;
        grant_b = bus.B_Valid;
      end
    end

    if (grant_a) begin
      last_next = REQ_A;
      wr_next   = bus.A_Wr;
      d_next    = bus.A_D;
      we_next   = (bus.A_Wr != '0);
      if ((bus.A_Wr != '0) && (cnt_a_reg != CNT_MAX)) begin
        cnt_a_next = cnt_a_reg + CNT_ONE;
      end
    end else if (grant_b) begin
      last_next = REQ_B;
      wr_next   = bus.B_Wr;
      d_next    = bus.B_D;
      we_next   = (bus.B_Wr != '0);
      if ((bus.B_Wr != '0) && (cnt_b_reg != CNT_MAX)) begin
        cnt_b_next = cnt_b_reg + CNT_ONE;
      end
    end
  end

  // State registers; reset discards any staged write immediately
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      last_reg  <= REQ_B;
      we_reg    <= 1'b0;
      wr_reg    <= '0;
      d_reg     <= '0;
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else begin
      last_reg  <= last_next;
      we_reg    <= we_next;
      wr_reg    <= wr_next;
      d_reg     <= d_next;
      cnt_a_reg <= cnt_a_next;
      cnt_b_reg <= cnt_b_next;
    end
  end

  // Read-after-write bypass from the staged write; r0 never bypasses
  always_comb begin
    bus.Qa = bus.Qa_rf;
    bus.Qb = bus.Qb_rf;
    if (we_reg && (wr_reg == bus.Ra) && (bus.Ra != '0)) begin
      bus.Qa = d_reg;
    end
    if (we_reg && (wr_reg == bus.Rb) && (bus.Rb != '0)) begin
      bus.Qb = d_reg;
    end
  end

  assign bus.A_Ready = grant_a;
  assign bus.B_Ready = grant_b;
  assign bus.We      = we_reg;
  assign bus.Wr      = wr_reg;
  assign bus.D       = d_reg;
  assign bus.Cnt_a   = cnt_a_reg;
  assign bus.Cnt_b   = cnt_b_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected register-file
// writes, a negedge monitor pops them whenever We is high. Handshake, counter and
// bypass values are checked inline against hand-computed constants.
module tb_regfile_wb_arbiter;

  logic Clk;
  logic Clrn;

  int vectors;
  int miscompares;

  logic [36:0] wr_q[$];

  regfile_wb_arbiter_if #(.AW(5), .DW(32), .CW(16)) bus ();
  regfile_wb_arbiter_if #(.AW(5), .DW(32), .CW(2))  bus2 ();

  regfile_wb_arbiter #(.AW(5), .DW(32), .CW(16)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .bus  (bus)
  );

  regfile_wb_arbiter #(.AW(5), .DW(32), .CW(2)) dut_sat (
    .Clk  (Clk),
    .Clrn (Clrn),
    .bus  (bus2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every committed write must match the oldest expected write
  always @(negedge Clk) begin
    if (Clrn && bus.We) begin
      logic [36:0] e;
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got Wr=%0d D=0x%0h, expected no write", bus.Wr, bus.D);
      end else begin
        e = wr_q.pop_front();
        if ({bus.Wr, bus.D} !== e) begin
          miscompares++;
          $display("FAIL write: got Wr=%0d D=0x%0h, expected Wr=%0d D=0x%0h",
                   bus.Wr, bus.D, e[36:32], e[31:0]);
        end else begin
          $display("ok   write Wr=%0d D=0x%0h", bus.Wr, bus.D);
        end
      end
    end
  end

  // One cycle of stimulus: drive at negedge, check grants, record expected write
  task automatic drive(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                       input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                       input logic hold, input logic exp_ar, input logic exp_br,
                       input string tag);
    @(negedge Clk);
    bus.A_Valid = av;
    bus.A_Wr    = aw;
    bus.A_D     = ad;
    bus.B_Valid = bv;
    bus.B_Wr    = bw;
    bus.B_D     = bd;
    bus.Hold    = hold;
    #1;
    chk({tag, "_a_ready"}, {63'd0, bus.A_Ready}, {63'd0, exp_ar});
    chk({tag, "_b_ready"}, {63'd0, bus.B_Ready}, {63'd0, exp_br});
    if (exp_ar && aw != 5'd0) wr_q.push_back({aw, ad});
    if (exp_br && bw != 5'd0) wr_q.push_back({bw, bd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    Clrn = 1'b0;
    #1;
    wr_q.delete();
    @(negedge Clk);
    Clrn = 1'b1;
  endtask

  initial begin
    int na;
    int nb;
    vectors     = 0;
    miscompares = 0;
    Clrn        = 1'b0;
    bus.Hold = 0; bus.A_Valid = 0; bus.A_Wr = 0; bus.A_D = 0;
    bus.B_Valid = 0; bus.B_Wr = 0; bus.B_D = 0;
    bus.Ra = 0; bus.Rb = 0; bus.Qa_rf = 0; bus.Qb_rf = 0;
    bus2.Hold = 0; bus2.A_Valid = 0; bus2.A_Wr = 0; bus2.A_D = 0;
    bus2.B_Valid = 0; bus2.B_Wr = 0; bus2.B_D = 0;
    bus2.Ra = 0; bus2.Rb = 0; bus2.Qa_rf = 0; bus2.Qb_rf = 0;

    repeat (2) @(negedge Clk);
    chk("rst_we", {63'd0, bus.We}, 64'd0);
    chk("rst_cnt_a", {48'd0, bus.Cnt_a}, 64'd0);
    Clrn = 1'b1;

    // 1. Reset mid-write, then a single A write
    drive(1, 5'd9, 32'h55, 0, 0, 0, 0, 1, 0, "t1_pre");
    @(posedge Clk);
    #2;
    chk("t1_staged_we", {63'd0, bus.We}, 64'd1);
    bus.B_Valid = 1'b1;
    Clrn = 1'b0;
    #1;
    chk("t1_rst_we", {63'd0, bus.We}, 64'd0);
    chk("t1_rst_wr", {59'd0, bus.Wr}, 64'd0);
    chk("t1_rst_d", {32'd0, bus.D}, 64'd0);
    chk("t1_rst_cnt_a", {48'd0, bus.Cnt_a}, 64'd0);
    chk("t1_rst_cnt_b", {48'd0, bus.Cnt_b}, 64'd0);
    chk("t1_rst_a_ready", {63'd0, bus.A_Ready}, 64'd0);
    chk("t1_rst_b_ready", {63'd0, bus.B_Ready}, 64'd0);
    wr_q.delete();
    bus.A_Valid = 1'b0;
    bus.B_Valid = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1;
    drive(1, 5'd5, 32'h1234, 0, 0, 0, 0, 1, 0, "t1");
    idle(1);
    chk("t1_we", {63'd0, bus.We}, 64'd1);
    chk("t1_cnt_a", {48'd0, bus.Cnt_a}, 64'd1);
    idle(1);

    // 2. Contention from reset: A,B,A,B,A,B
    reset_dut();
    na = 0;
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        drive(1, 5'd3, 32'hA000 + na, 1, 5'd4, 32'hB000 + nb, 0, 1, 0, "t2");
        na++;
      end else begin
        drive(1, 5'd3, 32'hA000 + na, 1, 5'd4, 32'hB000 + nb, 0, 0, 1, "t2");
        nb++;
      end
    end
    idle(1);
    chk("t2_cnt_a", {48'd0, bus.Cnt_a}, 64'd3);
    chk("t2_cnt_b", {48'd0, bus.Cnt_b}, 64'd3);

    // 3. Write to r0 is consumed without a register-file write
    drive(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0, 1, "t3");
    idle(1);
    chk("t3_we", {63'd0, bus.We}, 64'd0);
    chk("t3_cnt_b", {48'd0, bus.Cnt_b}, 64'd3);

    // 4. Hold: staged B write drains, pointer keeps B so A wins afterwards
    drive(0, 0, 0, 1, 5'd8, 32'h88, 0, 0, 1, "t4_stage");
    for (int i = 0; i < 3; i++) drive(1, 5'd2, 32'h22, 1, 5'd10, 32'hAA, 1, 0, 0, "t4_hold");
    drive(1, 5'd2, 32'h22, 1, 5'd10, 32'hAA, 0, 1, 0, "t4_rel_a");
    drive(0, 0, 0, 1, 5'd10, 32'hAA, 0, 0, 1, "t4_rel_b");
    idle(2);

    // 5. Bypass during the We cycle
    drive(1, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, "t5");
    idle(1);
    bus.Ra = 5'd7; bus.Qa_rf = 32'h0; bus.Rb = 5'd7; bus.Qb_rf = 32'h1;
    #1;
    chk("t5_qa_hit", {32'd0, bus.Qa}, 64'hDEADBEEF);
    chk("t5_qb_hit", {32'd0, bus.Qb}, 64'hDEADBEEF);
    bus.Ra = 5'd0; bus.Qa_rf = 32'h5A;
    bus.Rb = 5'd3; bus.Qb_rf = 32'h33;
    #1;
    chk("t5_qa_r0", {32'd0, bus.Qa}, 64'h5A);
    chk("t5_qb_miss", {32'd0, bus.Qb}, 64'h33);
    idle(1);
    bus.Ra = 5'd7; bus.Qa_rf = 32'h77;
    #1;
    chk("t5_qa_no_we", {32'd0, bus.Qa}, 64'h77);

    // 6. Saturating counter on the CW=2 instance
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      bus2.A_Valid = 1'b1;
      bus2.A_Wr    = 5'd1;
      bus2.A_D     = 32'h100 + k;
      #1;
      chk("t6_a_ready", {63'd0, bus2.A_Ready}, 64'd1);
      @(negedge Clk);
      bus2.A_Valid = 1'b0;
      #1;
      chk("t6_we", {63'd0, bus2.We}, 64'd1);
      chk("t6_d", {32'd0, bus2.D}, 64'h100 + k);
      chk("t6_cnt_a", {62'd0, bus2.Cnt_a}, (k + 1 > 3) ? 64'd3 : 64'(k + 1));
    end

    idle(3);
    chk("scoreboard_drained", 64'(wr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
